ps2_key_ctrl: RTL and testbench

PS2_KEY_CTRL -- requirements
Module: ps2_key_ctrl

---
 rtl/ps2_key_ctrl.sv | 90 +++++++++
 tb/tb_ps2_key_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: pops PS/2 scan bytes from a receiver FIFO and decodes make/break/repeat key events
module ps2_key_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ready,
  input  logic [7:0] data,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_rpt,
  output logic       key_held,
  output logic [7:0] cur_code,
  output logic       cur_ext,
  output logic [7:0] press_cnt,
  output logic       shift,
  output logic       caps,
  output logic       ovf_sticky
);
  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;
  state_t state;
  logic ext_pend, brk_pend, sh_l, sh_r;
  logic is_e0, is_f0, match;
  assign is_e0 = data == 8'hE0;
  assign is_f0 = data == 8'hF0;
  assign match = key_held && cur_ext == ext_pend && cur_code == data;
  assign shift = sh_l | sh_r;
  // The byte is decoded on the same edge it is latched so the event is visible during POP.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      nextdata_n <= 1'b1;
      key_valid  <= 1'b0;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_break  <= 1'b0;
      key_rpt    <= 1'b0;
      key_held   <= 1'b0;
      cur_code   <= 8'h00;
      cur_ext    <= 1'b0;
      press_cnt  <= 8'h00;
      sh_l       <= 1'b0;
      sh_r       <= 1'b0;
      caps       <= 1'b0;
      ovf_sticky <= 1'b0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
    end else begin
      if (overflow) ovf_sticky <= 1'b1;
      unique case (state)
        IDLE: if (ready) begin
          state      <= POP;
          nextdata_n <= 1'b0;
          if (is_e0) ext_pend <= 1'b1;
          else if (is_f0) brk_pend <= 1'b1;
          else begin
            key_valid <= 1'b1;
            key_code  <= data;
            key_ext   <= ext_pend;
            key_break <= brk_pend;
            key_rpt   <= !brk_pend && match;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            if (!ext_pend && data == 8'h12) sh_l <= !brk_pend;
            if (!ext_pend && data == 8'h59) sh_r <= !brk_pend;
            if (brk_pend) begin
              if (match) begin
                key_held  <= 1'b0;
                press_cnt <= press_cnt + 8'd1;
              end
            end else if (!match) begin
              key_held <= 1'b1;
              cur_code <= data;
              cur_ext  <= ext_pend;
              if (!ext_pend && data == 8'h58) caps <= !caps;
            end
          end
        end
        POP: begin
          state      <= GAP;
          nextdata_n <= 1'b1;
          key_valid  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: FIFO-driven randomized bench with a scan-code reference model
module tb_ps2_key_ctrl;
  logic clk, clrn, ready, overflow;
  logic [7:0] data;
  logic nextdata_n, key_valid, key_ext, key_break, key_rpt, key_held, cur_ext, shift, caps, ovf_sticky;
  logic [7:0] key_code, cur_code, press_cnt;

  ps2_key_ctrl dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .key_rpt(key_rpt), .key_held(key_held), .cur_code(cur_code),
    .cur_ext(cur_ext), .press_cnt(press_cnt), .shift(shift), .caps(caps), .ovf_sticky(ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, pops = 0, rpts = 0;
  logic [7:0] q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  bit m_ext, m_brk, m_held, m_cext, m_shl, m_shr, m_caps, e_ext, e_brk, e_rpt;
  logic [7:0] m_ccode, m_cnt, e_code;

  task automatic m_reset();
    {m_ext, m_brk, m_held, m_cext, m_shl, m_shr, m_caps, e_ext, e_brk, e_rpt} = '0;
    m_ccode = 0; m_cnt = 0; e_code = 0;
  endtask

  task automatic model(input logic [7:0] b, output bit ev);
    bit same;
    ev = 0;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      ev = 1; e_code = b; e_ext = m_ext; e_brk = m_brk;
      same = m_held && m_cext == m_ext && m_ccode == b;
      e_rpt = !m_brk && same;
      if (m_brk && same) begin m_held = 0; m_cnt = m_cnt + 1; end
      if (!m_brk && !same) begin
        m_held = 1; m_ccode = b; m_cext = m_ext;
        if (!m_ext && b == 8'h58) m_caps = !m_caps;
      end
      if (!m_ext && b == 8'h12) m_shl = !m_brk;
      if (!m_ext && b == 8'h59) m_shr = !m_brk;
      m_ext = 0; m_brk = 0;
    end
  endtask

  // FIFO emulation plus per-cycle comparison against the model, all on the falling edge.
  initial begin
    bit ev;
    logic [7:0] b;
    ready = 0; data = 0;
    m_reset();
    forever begin
      @(negedge clk);
      if (!clrn) m_reset();
      else begin
        ev = 0;
        if (!nextdata_n) begin
          pops++;
          if (q.size() == 0) check("spurious_pop", 1, 0);
          else begin b = q.pop_front(); model(b, ev); end
        end
        if (key_valid && key_rpt) rpts++;
        check("key_valid", 64'(key_valid), 64'(ev));
        check("key_code", 64'(key_code), 64'(e_code));
        check("key_ext", 64'(key_ext), 64'(e_ext));
        check("key_break", 64'(key_break), 64'(e_brk));
        if (ev && !e_brk) check("key_rpt", 64'(key_rpt), 64'(e_rpt));
        check("key_held", 64'(key_held), 64'(m_held));
        check("cur", 64'({cur_ext, cur_code}), 64'({m_cext, m_ccode}));
        check("press_cnt", 64'(press_cnt), 64'(m_cnt));
        check("shift", 64'(shift), 64'(m_shl | m_shr));
        check("caps", 64'(caps), 64'(m_caps));
      end
      ready = q.size() != 0;
      data = ready ? q[0] : 8'($urandom);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] bs[$]);
    int n = 0;
    foreach (bs[i]) q.push_back(bs[i]);
    while (q.size() != 0 && n < 5000) begin tick(); n++; end
    check("drain_timeout", 64'(q.size()), 0);
    tick(4);
  endtask

  function automatic logic [63:0] outs();
    return 64'({nextdata_n, key_valid, key_code, key_ext, key_break, key_rpt, key_held,
                cur_code, cur_ext, press_cnt, shift, caps, ovf_sticky});
  endfunction

  task automatic do_reset();
    tick();
    clrn = 0;
    q.delete();
    #1 check("async_reset_outs", outs(), 64'h2_0000_0000);
    tick(2);
    check("reset_outs", outs(), 64'h2_0000_0000);
    clrn = 1;
    tick();
  endtask

  localparam logic [7:0] POOL [8] = '{8'h12, 8'h59, 8'h58, 8'h1C, 8'h75, 8'hE0, 8'hF0, 8'h1C};

  initial begin
    int p0, r0;
    logic [7:0] bs[$];
    clrn = 0; overflow = 0;
    tick(2);
    check("init_outs", outs(), 64'h2_0000_0000);
    clrn = 1;
    tick();
    p0 = pops;
    send('{8'h1C, 8'hF0, 8'h1C});
    check("s1_pops", 64'(pops - p0), 3);
    check("s1_cnt", 64'(press_cnt), 1);
    check("s1_held", 64'(key_held), 0);
    r0 = rpts;
    send('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C});
    check("s2_rpts", 64'(rpts - r0), 2);
    check("s2_cnt", 64'(press_cnt), 2);
    send('{8'hE0, 8'h75});
    check("s3_cur_ext", 64'({key_held, cur_ext, cur_code}), 64'({2'b11, 8'h75}));
    send('{8'hE0, 8'hF0, 8'h75});
    check("s3_break", 64'({key_ext, key_break, key_held}), 64'(3'b110));
    send('{8'h58});
    check("s4_caps_on", 64'(caps), 1);
    send('{8'hF0, 8'h58, 8'h58, 8'h58, 8'hF0, 8'h58});
    check("s4_caps_off", 64'(caps), 0);
    send('{8'h12, 8'h59, 8'hF0, 8'h12});
    check("s4_shift_on", 64'(shift), 1);
    send('{8'hF0, 8'h59});
    check("s4_shift_off", 64'(shift), 0);
    for (int i = 0; i < 300; i++) bs.push_back($urandom_range(0, 9) < 8 ? POOL[$urandom_range(0, 7)] : 8'($urandom));
    send(bs);
    do_reset();
    bs.delete();
    for (int i = 0; i < 255; i++) begin bs.push_back(8'h1C); bs.push_back(8'hF0); bs.push_back(8'h1C); end
    send(bs);
    check("s5_cnt_ff", 64'(press_cnt), 8'hFF);
    send('{8'h1C, 8'hF0, 8'h1C});
    check("s5_cnt_wrap", 64'(press_cnt), 0);
    check("s5_ovf_pre", 64'(ovf_sticky), 0);
    overflow = 1;
    tick();
    overflow = 0;
    check("s5_ovf_set", 64'(ovf_sticky), 1);
    tick(5);
    check("s5_ovf_hold", 64'(ovf_sticky), 1);
    send('{8'h1C, 8'hE0, 8'hF0});
    do_reset();
    send('{8'h1C});
    check("s6_after_reset", 64'({key_code, key_ext, key_break, key_held}), 64'({8'h1C, 3'b001}));
    check("s6_ovf_cleared", 64'(ovf_sticky), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
